// File: rtl/uart_tx_driver.sv
// 8N1 UART transmitter with a small circular byte FIFO in front of the shifter.
// Frames go out back-to-back at CLKS_PER_BIT sysClock cycles per bit.
module uart_tx_driver #(
   parameter int CLKS_PER_BIT = 417,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          sysClock,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          busy,
   output logic                          overflow,
   output logic                          tx_out
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_TC  = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state_r, state_nxt_s;
   logic [7:0]      mem_r [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [AW:0]     count_r, count_nxt_s;
   logic            full_r, empty_r, busy_r, overflow_r, tx_out_r;
   logic [CW-1:0]   baud_r, baud_nxt_s;
   logic [2:0]      bit_idx_r, bit_idx_nxt_s;
   logic [7:0]      shift_r, shift_nxt_s;
   logic            tx_nxt_s, busy_nxt_s, pop_s, push_s, baud_tc_s;

   assign full     = full_r;
   assign empty    = empty_r;
   assign count    = count_r;
   assign busy     = busy_r;
   assign overflow = overflow_r;
   assign tx_out   = tx_out_r;

   assign baud_tc_s = (baud_r == BAUD_TC);
   // full is the registered flag, so a write while full is dropped even if this edge pops
   assign push_s    = wr_en & ~full_r;

   // State register, FIFO bookkeeping and registered outputs
   always_ff @(posedge sysClock) begin
      if (reset) begin
         state_r    <= IDLE;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         busy_r     <= 1'b0;
         overflow_r <= 1'b0;
         tx_out_r   <= 1'b1;
         baud_r     <= '0;
         bit_idx_r  <= 3'd0;
         shift_r    <= 8'd0;
      end else begin
         state_r    <= state_nxt_s;
         wr_ptr_r   <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
         rd_ptr_r   <= pop_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
         count_r    <= count_nxt_s;
         full_r     <= (count_nxt_s == DEPTH_C);
         empty_r    <= (count_nxt_s == '0);
         busy_r     <= busy_nxt_s;
         overflow_r <= overflow_r | (wr_en & full_r);
         tx_out_r   <= tx_nxt_s;
         baud_r     <= baud_nxt_s;
         bit_idx_r  <= bit_idx_nxt_s;
         shift_r    <= shift_nxt_s;
      end
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge sysClock) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Next-state, pop decision and baud/bit counters
   always_comb begin
      state_nxt_s   = state_r;
      pop_s         = 1'b0;
      baud_nxt_s    = baud_r;
      bit_idx_nxt_s = bit_idx_r;
      case (state_r)
         IDLE: begin
            baud_nxt_s    = '0;
            bit_idx_nxt_s = 3'd0;
            if (!empty_r) begin
               pop_s       = 1'b1;
               state_nxt_s = START;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (baud_tc_s) begin
               baud_nxt_s    = '0;
               bit_idx_nxt_s = 3'd0;
               state_nxt_s   = DATA;
            end else begin
               baud_nxt_s = baud_r + CW'(1);
            end
         end
         DATA: begin
            if (baud_tc_s) begin
               baud_nxt_s = '0;
               if (bit_idx_r == 3'd7) begin
                  state_nxt_s = STOP;
               end else begin
                  bit_idx_nxt_s = bit_idx_r + 3'd1;
               end
            end else begin
               baud_nxt_s = baud_r + CW'(1);
            end
         end
         STOP: begin
            if (baud_tc_s) begin
               baud_nxt_s = '0;
               if (!empty_r) begin
                  pop_s       = 1'b1;
                  state_nxt_s = START;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               baud_nxt_s = baud_r + CW'(1);
            end
         end
         default: begin
            state_nxt_s = IDLE;
            baud_nxt_s  = '0;
         end
      endcase
      count_nxt_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
   end

   // Line level and shifter; the shifter moves right so the next bit is always shift_r[1]
   always_comb begin
      tx_nxt_s    = tx_out_r;
      shift_nxt_s = shift_r;
      case (state_r)
         IDLE: begin
            if (pop_s) begin
               shift_nxt_s = mem_r[rd_ptr_r];
               tx_nxt_s    = 1'b0;
            end else begin
               tx_nxt_s = 1'b1;
            end
         end
         START: begin
            if (baud_tc_s) begin
               tx_nxt_s = shift_r[0];
            end else begin
               tx_nxt_s = 1'b0;
            end
         end
         DATA: begin
            if (baud_tc_s) begin
               if (bit_idx_r == 3'd7) begin
                  tx_nxt_s = 1'b1;
               end else begin
                  tx_nxt_s    = shift_r[1];
                  shift_nxt_s = {1'b0, shift_r[7:1]};
               end
            end else begin
               tx_nxt_s = tx_out_r;
            end
         end
         STOP: begin
            if (pop_s) begin
               shift_nxt_s = mem_r[rd_ptr_r];
               tx_nxt_s    = 1'b0;
            end else begin
               tx_nxt_s = 1'b1;
            end
         end
         default: begin
            tx_nxt_s = 1'b1;
         end
      endcase
      busy_nxt_s = (state_nxt_s != IDLE);
   end

endmodule

// File: tb/tb_uart_tx_driver.sv
// Directed bench: writes are pushed to an expected-byte queue and a line
// receiver process decodes each frame and compares against that queue.
module tb_uart_tx_driver;

   logic       sysClock = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full, empty, busy, overflow, tx_out;
   logic [2:0] count;

   int         cyc = 0;
   int         rst_cnt = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q[$];
   int         starts[$];

   uart_tx_driver #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
      .sysClock (sysClock),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .busy     (busy),
      .overflow (overflow),
      .tx_out   (tx_out)
   );

   always #5 sysClock = ~sysClock;

   always @(posedge sysClock) begin
      cyc <= cyc + 1;
      if (reset) rst_cnt <= rst_cnt + 1;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int st(input int k);
      return (k < starts.size()) ? starts[k] : -1;
   endfunction

   task automatic wait_to(input int k);
      while (cyc < k) @(negedge sysClock);
   endtask

   // write lands on the next rising edge; returns at the following negedge
   task automatic wr(input logic [7:0] d, input bit accept);
      wr_en   = 1'b1;
      wr_data = d;
      if (accept) exp_q.push_back(d);
      @(negedge sysClock);
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge sysClock);
      reset = 1'b1;
      @(negedge sysClock);
      reset = 1'b0;
      exp_q.delete();
      starts.delete();
   endtask

   // Line receiver: samples mid-bit at 4 clocks per bit, drops frames cut by reset
   initial begin
      int         t0, rc;
      logic [7:0] b;
      logic       sb, pb;
      logic [9:0] act, exp;
      forever begin
         @(negedge sysClock);
         if (reset === 1'b0 && tx_out === 1'b0) begin
            t0 = cyc;
            rc = rst_cnt;
            repeat (2) @(negedge sysClock);
            sb = tx_out;
            for (int i = 0; i < 8; i++) begin
               repeat (4) @(negedge sysClock);
               b[i] = tx_out;
            end
            repeat (4) @(negedge sysClock);
            pb = tx_out;
            if (rst_cnt == rc) begin
               act = {pb, b, sb};
               starts.push_back(t0);
               if (exp_q.size() == 0) begin
                  chk("frame_unexpected", int'(act), -1);
               end else begin
                  exp = {1'b1, exp_q.pop_front(), 1'b0};
                  chk("frame_data", int'(act), int'(exp));
               end
            end
         end
      end
   end

   initial begin
      int n, chg, bz, lows;
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      repeat (3) @(negedge sysClock);
      chk("rst_tx_out",   int'(tx_out),   1);
      chk("rst_empty",    int'(empty),    1);
      chk("rst_full",     int'(full),     0);
      chk("rst_count",    int'(count),    0);
      chk("rst_busy",     int'(busy),     0);
      chk("rst_overflow", int'(overflow), 0);
      reset = 1'b0;
      chg = 0;
      repeat (50) begin
         @(negedge sysClock);
         if ({tx_out, empty, full, count, busy, overflow} !== 8'b1100_0000) chg++;
      end
      chk("idle_hold_changes", chg, 0);

      // single byte 0xA5
      starts.delete();
      n = cyc + 1;
      wr(8'hA5, 1'b1);
      chk("single_count_after_wr", int'(count), 1);
      chk("single_tx_before_start", int'(tx_out), 1);
      @(negedge sysClock);
      chk("single_tx_start", int'(tx_out), 0);
      chk("single_busy_start", int'(busy), 1);
      chk("single_count_after_pop", int'(count), 0);
      chk("single_empty_after_pop", int'(empty), 1);
      wait_to(n + 40);
      chk("single_busy_last_stop", int'(busy), 1);
      @(negedge sysClock);
      chk("single_busy_fall", int'(busy), 0);
      chk("single_tx_idle", int'(tx_out), 1);
      chk("single_start_cycle", st(0), n + 1);

      // back-to-back 0x55 0x00 0xFF
      starts.delete();
      n = cyc + 1;
      wr(8'h55, 1'b1);
      wr(8'h00, 1'b1);
      wr(8'hFF, 1'b1);
      bz = 0;
      while (cyc < n + 120) begin
         @(negedge sysClock);
         if (!busy) bz++;
      end
      chk("b2b_busy_gaps", bz, 0);
      @(negedge sysClock);
      chk("b2b_busy_fall", int'(busy), 0);
      wait_to(n + 125);
      chk("b2b_frames", starts.size(), 3);
      chk("b2b_first_start", st(0), n + 1);
      chk("b2b_gap_1", st(1) - st(0), 40);
      chk("b2b_gap_2", st(2) - st(1), 40);

      // overflow: 0x06 is dropped
      do_reset();
      n = cyc + 1;
      for (int i = 1; i <= 5; i++) wr(8'(i), 1'b1);
      chk("ovf_full", int'(full), 1);
      chk("ovf_count_full", int'(count), 4);
      chk("ovf_not_yet", int'(overflow), 0);
      wr(8'h06, 1'b0);
      chk("ovf_set", int'(overflow), 1);
      chk("ovf_count_held", int'(count), 4);
      wait_to(n + 230);
      chk("ovf_sticky", int'(overflow), 1);
      chk("ovf_frames", starts.size(), 5);
      chk("ovf_queue_drained", exp_q.size(), 0);

      // write while full on the STOP terminal edge that pops
      do_reset();
      n = cyc + 1;
      for (int i = 0; i < 5; i++) wr(8'h11 + 8'(i), 1'b1);
      wait_to(n + 40);
      chk("wfp_full_before", int'(full), 1);
      chk("wfp_ovf_before", int'(overflow), 0);
      wr(8'h77, 1'b0);
      chk("wfp_count", int'(count), 3);
      chk("wfp_full_after", int'(full), 0);
      chk("wfp_overflow", int'(overflow), 1);
      wait_to(n + 230);
      chk("wfp_queue_drained", exp_q.size(), 0);

      // reset during DATA bit 3 with two bytes queued
      do_reset();
      n = cyc + 1;
      wr(8'hC1, 1'b0);
      wr(8'hC2, 1'b0);
      wr(8'hC3, 1'b0);
      wait_to(n + 17);
      chk("mid_count_before", int'(count), 2);
      reset = 1'b1;
      @(negedge sysClock);
      chk("mid_rst_tx_out", int'(tx_out), 1);
      chk("mid_rst_empty", int'(empty), 1);
      chk("mid_rst_count", int'(count), 0);
      chk("mid_rst_busy", int'(busy), 0);
      reset = 1'b0;
      lows = 0;
      repeat (60) begin
         @(negedge sysClock);
         if (tx_out !== 1'b1) lows++;
      end
      chk("mid_no_more_frames", lows, 0);
      starts.delete();
      wr(8'h3C, 1'b1);
      repeat (50) @(negedge sysClock);
      chk("mid_3c_frames", starts.size(), 1);
      chk("mid_queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_driver.md
Name: uart_tx_driver

Overview:
- Byte-serialising UART transmitter (8N1) that drives the SoC's `uart_rx_in` line from the simulation top level.
- It is the transmitting end of the link whose receiver lives inside the SoC.
- A small byte FIFO accepts writes from the sim state machine or bench and emits frames back-to-back at a fixed baud set by a clock divider.
- The same block can also be instantiated inside the SoC as its transmit path.

Parameters:
- CLKS_PER_BIT, 417, `sysClock` cycles per bit (48 MHz / 115200, rounded); legal range 2..65535.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, ≥2.

Ports:
- sysClock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe; accepts `wr_data` on the rising edge when `full`=0.
- wr_data  in  8  byte to transmit.
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.
- busy  out  1  high whenever state≠IDLE.
- overflow  out  1  sticky; set when `wr_en`=1 while `full`=1; cleared only by reset.
- tx_out  out  1  serial line, idle high; connects to SoC `uart_rx_in`.

Behaviour:
- Reset (synchronous, sampled on a `sysClock` edge with `reset`=1):
  - state=IDLE, `tx_out`=1, FIFO pointers=0, `count`=0, `empty`=1, `full`=0, `busy`=0, `overflow`=0, bit counter=0, baud counter=0.
  - Reset mid-frame aborts the frame; `tx_out` returns to 1 on the reset edge; queued bytes are discarded.
- All outputs are registered. `full`, `empty` and `count` reflect FIFO state after the most recent edge.
- Write rule:
  - `full` is sampled before any same-cycle pop. `wr_en` with `full`=1 drops the byte and sets `overflow`, even if a pop occurs that edge.
  - `wr_en` with `full`=0 always enqueues, including on the same edge as a pop. In that case `count` is unchanged.
- FIFO is circular; read and write pointers wrap modulo FIFO_DEPTH.
- State machine (IDLE, START, DATA, STOP):
  - IDLE: `tx_out`=1. If `empty`=0, on the next edge pop the head into the shift register, set `tx_out`=0, clear the baud counter, and go to START.
  - START: hold `tx_out`=0 for CLKS_PER_BIT cycles. On the terminal count edge, drive bit0 and go to DATA with bit index 0.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. On terminal count:
    - if index<7: increment and drive the next bit;
    - if index=7: drive `tx_out`=1 and go to STOP.
  - STOP: hold `tx_out`=1 for CLKS_PER_BIT cycles. On terminal count:
    - if `empty`=0, pop, drive `tx_out`=0 and go to START, with no idle gap between frames;
    - otherwise go to IDLE.
- Latency: a `wr_en` at edge N into an empty FIFO while IDLE gives `tx_out` falling after edge N+1.
- Frame timing:
  - one frame = exactly 10×CLKS_PER_BIT cycles of `tx_out`;
  - N back-to-back bytes occupy 10×N×CLKS_PER_BIT contiguous cycles.
- Baud counter counts 0..CLKS_PER_BIT-1; terminal count is CLKS_PER_BIT-1. Width is $clog2(CLKS_PER_BIT).
- `busy` is 1 from the START entry edge through the final STOP cycle. It stays 1 across back-to-back frames.
- `count` excludes the byte in the shift register. A popped byte frees its FIFO slot on the pop edge.

Test Plan:
- Reset → `tx_out`=1, `empty`=1, `full`=0, `count`=0, `busy`=0, `overflow`=0; hold 50 cycles with `wr_en`=0 → no change.
- Single byte (CLKS_PER_BIT=4):
  - stimulus: write 0xA5 at edge N;
  - `tx_out` low from edge N+1 for 4 cycles;
  - bits 1,0,1,0,0,1,0,1 at 4 cycles each;
  - stop high for 4 cycles;
  - `busy` falls at edge N+41.
- Back-to-back (CLKS_PER_BIT=4):
  - stimulus: write 0x55, 0x00, 0xFF on three consecutive edges;
  - 120 contiguous line cycles with no idle gap between stop and start;
  - the receiver model decodes 0x55, 0x00, 0xFF.
- Overflow (CLKS_PER_BIT=4, FIFO_DEPTH=4):
  - stimulus: 6 consecutive writes 0x01..0x06;
  - 0x01 is popped into the shifter, 0x02..0x05 fill the FIFO (`full`=1, `count`=4);
  - the write of 0x06 is dropped and sets `overflow`=1;
  - the line emits 0x01..0x05 only; `overflow` stays 1 afterwards.
- Write while full with simultaneous pop:
  - stimulus: `full`=1 and `wr_en`=1 on the STOP terminal edge;
  - the byte is dropped, `overflow`=1, `count` goes 4→3.
- Reset mid-frame:
  - stimulus: assert `reset` during DATA bit 3 with 2 bytes queued;
  - `tx_out`=1 and `empty`=1 on the reset edge;
  - no further frames follow; a subsequent write of 0x3C transmits cleanly.
